// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry collector.
//   KEY_CLEAR / KEY_ENTER / MAX_DIGIT : key code map (0-9 digits, A clear, B enter, C-F ignored)
//   coll_state_t                      : collector state encoding
//   is_action_key()                   : true for codes that produce a key event
package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] MAX_DIGIT = 4'h9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_REL_DB,
        ST_COMPLETE
    } coll_state_t;

    function automatic logic is_action_key(input logic [3:0] code);
        return code <= KEY_ENTER;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Press/release debouncer for the keypad encoder code/valid interface.
// Produces exactly one press strobe per debounced press and parks in
// COMPLETE when the owner says the accepted key finishes a PIN.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   key_code      raw code from the encoder
//   key_valid     high while a key is pressed
//   go_complete   owner: a press accepted now should park in COMPLETE
//   ack           owner: leave COMPLETE this edge
//   press         combinational strobe, press accepted at the coming edge
//   press_code    code belonging to the accepted press
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       go_complete,
    input  logic       ack,
    output logic       press,
    output logic [3:0] press_code
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW:0] DB_LAST = (CW + 1)'(DEBOUNCE_CYCLES);
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    coll_state_t   state, state_nxt;
    logic [3:0]    code_q, code_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW:0]   cnt_inc;

    assign cnt_inc    = {1'b0, cnt} + (CW + 1)'(1);
    assign press_code = key_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            code_q <= 4'h0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            code_q <= code_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        cnt_nxt   = cnt;
        press     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_valid) begin
                    code_nxt = key_code;
                    cnt_nxt  = CW'(1);
                    if (SINGLE) begin
                        press     = 1'b1;
                        state_nxt = go_complete ? ST_COMPLETE : ST_HELD;
                    end else begin
                        state_nxt = ST_PRESS_DB;
                    end
                end
            end
            ST_PRESS_DB: begin
                if (!key_valid) begin
                    state_nxt = ST_IDLE;
                end else if (key_code != code_q) begin
                    // a different key restarts the stability window
                    code_nxt = key_code;
                    cnt_nxt  = CW'(1);
                end else if (cnt_inc == DB_LAST) begin
                    press     = 1'b1;
                    state_nxt = go_complete ? ST_COMPLETE : ST_HELD;
                end else begin
                    cnt_nxt = cnt_inc[CW-1:0];
                end
            end
            ST_HELD: begin
                // code changes while held are deliberately ignored (no auto-repeat)
                if (!key_valid) begin
                    cnt_nxt   = CW'(1);
                    state_nxt = SINGLE ? ST_IDLE : ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (key_valid) begin
                    state_nxt = ST_HELD;
                end else if (cnt_inc == DB_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_inc[CW-1:0];
                end
            end
            ST_COMPLETE: begin
                // a key still down at ack must be released before it can count
                if (ack) state_nxt = key_valid ? ST_HELD : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/keypad_entry_collector.sv
// Keypad entry collector: debounces keypad codes, collects PIN_LEN digits
// and hands the PIN to the lock FSM over a valid/ack handshake.
// Optional feature macro: KEYPAD_TIMEOUT_EN (discard a partial entry after
// TIMEOUT_CYCLES cycles without a key event).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   key_code      encoder code (0-9 digit, A clear, B enter, C-F ignored)
//   key_valid     high while any key is pressed
//   pin_ack       consumer accepts pin_out (only looked at while pin_valid)
//   pin_out       collected PIN, first digit in the top nibble
//   pin_valid     PIN complete, held until pin_ack
//   digit_count   digits currently buffered
//   key_event     one-cycle pulse per accepted digit/CLEAR/ENTER
//   entry_error   one-cycle pulse on short ENTER or timeout
module keypad_entry_collector
    import keypad_pkg::*;
#(
    parameter int PIN_LEN         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           key_code,
    input  logic                 key_valid,
    input  logic                 pin_ack,
    output logic [4*PIN_LEN-1:0] pin_out,
    output logic                 pin_valid,
    output logic [3:0]           digit_count,
    output logic                 key_event,
    output logic                 entry_error
);

    localparam logic [3:0] PIN_LEN_C = 4'(PIN_LEN);

    logic                 press;
    logic [3:0]           press_code;
    logic                 accept;
    logic                 enter_full;
    logic                 ack_take;
    logic                 timeout_hit;
    logic [4*PIN_LEN-1:0] pin_buf;
    logic [4*PIN_LEN-1:0] pin_shifted;

    // enter_full is only consumed together with a press, when key_code is the pressed key
    assign enter_full = (key_code == KEY_ENTER) && (digit_count == PIN_LEN_C);
    assign ack_take   = pin_valid && pin_ack;
    assign accept     = press && is_action_key(press_code);
    assign pin_out    = pin_buf;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .go_complete(enter_full),
        .ack        (ack_take),
        .press      (press),
        .press_code (press_code)
    );

    if (PIN_LEN == 1) begin : g_one_digit
        assign pin_shifted = press_code;
    end else begin : g_multi_digit
        assign pin_shifted = {pin_buf[4*PIN_LEN-5:0], press_code};
    end

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW:0] TO_LAST = (TW + 1)'(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_cnt;
    logic [TW:0]   idle_inc;
    logic          idle_armed;

    assign idle_inc    = {1'b0, idle_cnt} + (TW + 1)'(1);
    assign idle_armed  = (digit_count != 4'd0) && !pin_valid;
    assign timeout_hit = !accept && idle_armed && (idle_inc == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || accept || !idle_armed || timeout_hit) idle_cnt <= '0;
        else                                              idle_cnt <= idle_inc[TW-1:0];
    end
`else
    // timeout compiled out: the parameter is kept only for a uniform interface
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pin_buf     <= '0;
            digit_count <= 4'd0;
            pin_valid   <= 1'b0;
            key_event   <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            key_event   <= 1'b0;
            entry_error <= 1'b0;
            if (ack_take) begin
                pin_valid   <= 1'b0;
                pin_buf     <= '0;
                digit_count <= 4'd0;
            end else if (accept) begin
                key_event <= 1'b1;
                if (press_code <= MAX_DIGIT) begin
                    // extra digits past PIN_LEN still pulse key_event but are dropped
                    if (digit_count < PIN_LEN_C) begin
                        pin_buf     <= pin_shifted;
                        digit_count <= digit_count + 4'd1;
                    end
                end else if (press_code == KEY_CLEAR) begin
                    pin_buf     <= '0;
                    digit_count <= 4'd0;
                end else if (enter_full) begin
                    pin_valid <= 1'b1;
                end else begin
                    entry_error <= 1'b1;
                    pin_buf     <= '0;
                    digit_count <= 4'd0;
                end
            end else if (timeout_hit) begin
                entry_error <= 1'b1;
                pin_buf     <= '0;
                digit_count <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_collector.sv
// Self-checking bench for keypad_entry_collector (PIN_LEN=4, DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=20). A run-length model of the keypad rules predicts the
// outputs every cycle; directed scenarios add literal expectations.
module tb_keypad_entry_collector;

    localparam int PIN_LEN = 4;
    localparam int DB      = 4;
    localparam int TO      = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_code = 4'h0;
    logic        key_valid = 1'b0;
    logic        pin_ack = 1'b0;
    logic [15:0] pin_out;
    logic        pin_valid;
    logic [3:0]  digit_count;
    logic        key_event;
    logic        entry_error;

    keypad_entry_collector #(
        .PIN_LEN(PIN_LEN),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .pin_ack(pin_ack), .pin_out(pin_out), .pin_valid(pin_valid),
        .digit_count(digit_count), .key_event(key_event), .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_digits[$];
    bit         m_valid, m_event, m_error;
    bit         armed = 1'b1;
    int         run, zrun, idle;
    logic [3:0] run_code;

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        w = 16'h0;
        foreach (m_digits[i]) w = {w[11:0], m_digits[i]};
        return w;
    endfunction

    task automatic model_apply(input logic [3:0] c);
        if (c <= 4'd9) begin
            m_event = 1'b1;
            if (m_digits.size() < PIN_LEN) m_digits.push_back(c);
        end else if (c == 4'hA) begin
            m_event = 1'b1;
            m_digits.delete();
        end else if (c == 4'hB) begin
            m_event = 1'b1;
            if (m_digits.size() == PIN_LEN) m_valid = 1'b1;
            else begin m_error = 1'b1; m_digits.delete(); end
        end
    endtask

    task automatic model_step();
        m_event = 1'b0;
        m_error = 1'b0;
        if (rst) begin
            m_digits.delete();
            m_valid = 1'b0; armed = 1'b1; run = 0; zrun = 0; idle = 0;
        end else if (m_valid) begin
            idle = 0;
            if (pin_ack) begin
                m_valid = 1'b0; m_digits.delete();
                armed = !key_valid; run = 0; zrun = 0;
            end
        end else begin
            if (armed) begin
                if (key_valid) begin
                    if (run > 0 && key_code == run_code) run++;
                    else begin run = 1; run_code = key_code; end
                    if (run == DB) begin
                        armed = 1'b0; zrun = 0;
                        model_apply(key_code);
                    end
                end else run = 0;
            end else begin
                if (!key_valid) begin
                    zrun++;
                    if (zrun == DB) begin armed = 1'b1; run = 0; zrun = 0; end
                end else zrun = 0;
            end
`ifdef KEYPAD_TIMEOUT_EN
            if (m_event) idle = 0;
            else if (m_digits.size() > 0 && !m_valid) begin
                idle++;
                if (idle == TO) begin idle = 0; m_digits.delete(); m_error = 1'b1; end
            end else idle = 0;
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (key_event)   ev_cnt++;
        if (entry_error) err_cnt++;
        if (chk_en) begin
            chk("pin_valid", 32'(pin_valid), 32'(m_valid));
            chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
            chk("key_event", 32'(key_event), 32'(m_event));
            chk("entry_error", 32'(entry_error), 32'(m_error));
            if (m_valid) chk("pin_out", 32'(pin_out), 32'(model_word()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] c, input int hold, input int gap);
        key_valid = 1'b1; key_code = c;
        cyc(hold);
        key_valid = 1'b0; key_code = 4'h0;
        cyc(gap);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (pin_valid !== 1'b1 && n < 30) begin cyc(1); n++; end
        chk(name, 32'(pin_valid), 32'd1);
    endtask

    task automatic do_ack();
        pin_ack = 1'b1; cyc(1); pin_ack = 1'b0;
    endtask

    initial begin
        int ev0, err0;
        cyc(3);
        chk("reset pin_valid", 32'(pin_valid), 32'd0);
        chk("reset digit_count", 32'(digit_count), 32'd0);
        chk("reset pin_out", 32'(pin_out), 32'd0);
        chk("reset key_event", 32'(key_event), 32'd0);
        chk("reset entry_error", 32'(entry_error), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1234 ENTER
        ev0 = ev_cnt;
        press_key(4'h1, 6, 6); press_key(4'h2, 6, 6);
        press_key(4'h3, 6, 6); press_key(4'h4, 6, 6);
        press_key(4'hB, 6, 6);
        wait_valid("s1 pin_valid");
        chk("s1 pin_out", 32'(pin_out), 32'h1234);
        chk("s1 events", 32'(ev_cnt - ev0), 32'd5);
        cyc(5);
        chk("s1 valid held", 32'(pin_valid), 32'd1);
        do_ack();
        chk("s1 after ack valid", 32'(pin_valid), 32'd0);
        chk("s1 after ack count", 32'(digit_count), 32'd0);
        cyc(4);

        // bounce shorter than the debounce window
        ev0 = ev_cnt;
        press_key(4'h7, 3, 6);
        chk("s2 no event", 32'(ev_cnt - ev0), 32'd0);
        chk("s2 count", 32'(digit_count), 32'd0);

        // 5 6 CLEAR 7 8 9 0 ENTER
        press_key(4'h5, 6, 6); press_key(4'h6, 6, 6);
        chk("s3 two digits", 32'(digit_count), 32'd2);
        press_key(4'hA, 6, 6);
        chk("s3 cleared", 32'(digit_count), 32'd0);
        press_key(4'h7, 6, 6); press_key(4'h8, 6, 6);
        press_key(4'h9, 6, 6); press_key(4'h0, 6, 6);
        press_key(4'hB, 6, 6);
        wait_valid("s3 pin_valid");
        chk("s3 pin_out", 32'(pin_out), 32'h7890);
        do_ack();
        cyc(4);

        // short ENTER
        err0 = err_cnt;
        press_key(4'h1, 6, 6); press_key(4'h2, 6, 6); press_key(4'hB, 6, 6);
        chk("s4 error pulses", 32'(err_cnt - err0), 32'd1);
        chk("s4 count", 32'(digit_count), 32'd0);
        chk("s4 pin_valid", 32'(pin_valid), 32'd0);

        // code change mid-debounce, ignored code 12
        key_valid = 1'b1; key_code = 4'h3; cyc(2);
        ev0 = ev_cnt;
        press_key(4'h5, 6, 6);
        chk("s5 restart event", 32'(ev_cnt - ev0), 32'd1);
        chk("s5 count", 32'(digit_count), 32'd1);
        ev0 = ev_cnt;
        press_key(4'hC, 8, 6);
        chk("s5 ignored code", 32'(ev_cnt - ev0), 32'd0);
        press_key(4'hA, 6, 6);

`ifndef KEYPAD_TIMEOUT_EN
        // five digits, fifth dropped, long hold yields one event
        press_key(4'h1, 6, 6); press_key(4'h2, 6, 6);
        press_key(4'h3, 6, 6); press_key(4'h4, 6, 6);
        ev0 = ev_cnt;
        press_key(4'h5, 40, 6);
        chk("s6 long hold events", 32'(ev_cnt - ev0), 32'd1);
        chk("s6 count", 32'(digit_count), 32'd4);
        press_key(4'hB, 6, 6);
        wait_valid("s6 pin_valid");
        chk("s6 pin_out", 32'(pin_out), 32'h1234);
        do_ack();
        cyc(4);
        // partial entry kept indefinitely
        press_key(4'h9, 6, 40);
        chk("s6 no timeout", 32'(digit_count), 32'd1);
        press_key(4'hA, 6, 6);
`else
        err0 = err_cnt;
        press_key(4'h9, 6, 24);
        chk("to error pulses", 32'(err_cnt - err0), 32'd1);
        chk("to count", 32'(digit_count), 32'd0);
`endif

        // reset in PRESS_DB
        press_key(4'h1, 6, 6);
        key_valid = 1'b1; key_code = 4'h2; cyc(2);
        rst = 1'b1; key_valid = 1'b0; cyc(1);
        chk("rst pdb count", 32'(digit_count), 32'd0);
        chk("rst pdb event", 32'(key_event), 32'd0);
        rst = 1'b0; cyc(4);

        // reset in COMPLETE
        press_key(4'h4, 6, 6); press_key(4'h3, 6, 6);
        press_key(4'h2, 6, 6); press_key(4'h1, 6, 6);
        press_key(4'hB, 6, 6);
        wait_valid("s7 pin_valid");
        chk("s7 pin_out", 32'(pin_out), 32'h4321);
        rst = 1'b1; cyc(1);
        chk("rst cmp valid", 32'(pin_valid), 32'd0);
        chk("rst cmp pin_out", 32'(pin_out), 32'd0);
        chk("rst cmp count", 32'(digit_count), 32'd0);
        rst = 1'b0; cyc(4);

        // ENTER still held at ack must not count again
        press_key(4'h8, 6, 6); press_key(4'h8, 6, 6);
        press_key(4'h8, 6, 6); press_key(4'h8, 6, 6);
        key_valid = 1'b1; key_code = 4'hB;
        cyc(8);
        chk("s8 pin_out", 32'(pin_out), 32'h8888);
        ev0 = ev_cnt;
        do_ack();
        cyc(10);
        key_valid = 1'b0; cyc(6);
        chk("s8 no re-press", 32'(ev_cnt - ev0), 32'd0);
        chk("s8 valid", 32'(pin_valid), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
